// File: rtl/ram_arbiter.sv
// Round-robin arbiter sharing one SDRAM request port among COUNT requesters, one transaction in flight.
// Optional watchdog on the WAIT state is built when RAM_ARB_WATCHDOG_EN is defined.
module ram_arbiter #(
  parameter  int COUNT      = 4,
  parameter  int ADDR_WIDTH = 23,
  parameter  int DATA_WIDTH = 32,
  parameter  int TIMEOUT    = 255,
  localparam int GW         = $clog2(COUNT),
  localparam int BW         = DATA_WIDTH / 8
) (
  input  logic                         CLK,
  input  logic                         RESET_n,
  input  logic [COUNT-1:0]             S_REQ,
  input  logic [COUNT-1:0]             S_WE,
  input  logic [COUNT*ADDR_WIDTH-1:0]  S_ADDR,
  input  logic [COUNT*DATA_WIDTH-1:0]  S_DIN,
  input  logic [COUNT*BW-1:0]          S_BE,
  output logic [COUNT-1:0]             S_ACK,
  output logic [DATA_WIDTH-1:0]        S_DOUT,
  output logic                         P_REQ,
  output logic                         P_WE,
  output logic [ADDR_WIDTH-1:0]        P_ADDR,
  output logic [DATA_WIDTH-1:0]        P_DIN,
  output logic [BW-1:0]                P_BE,
  input  logic                         P_ACK,
  input  logic [DATA_WIDTH-1:0]        P_DOUT,
  output logic [GW-1:0]                GRANT,
  output logic                         BUSY,
  output logic                         ERR
);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  // Flat ports viewed as packed per-lane arrays; layouts are identical.
  logic [COUNT-1:0][ADDR_WIDTH-1:0] addr_v;
  logic [COUNT-1:0][DATA_WIDTH-1:0] din_v;
  logic [COUNT-1:0][BW-1:0]         be_v;
  assign addr_v = S_ADDR;
  assign din_v  = S_DIN;
  assign be_v   = S_BE;

  state_t                 state_q, state_d;
  logic [GW-1:0]          last_q, last_d;
  logic [GW-1:0]          grant_q, grant_d;
  logic                   p_req_q, p_req_d;
  logic                   p_we_q, p_we_d;
  logic [ADDR_WIDTH-1:0]  p_addr_q, p_addr_d;
  logic [DATA_WIDTH-1:0]  p_din_q, p_din_d;
  logic [BW-1:0]          p_be_q, p_be_d;
  logic [COUNT-1:0]       s_ack_q, s_ack_d;
  logic [DATA_WIDTH-1:0]  s_dout_q, s_dout_d;
  logic [GW-1:0]          win;
  logic [GW-1:0]          idx;

`ifdef RAM_ARB_WATCHDOG_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;
`endif

  // Scan from last+1 upward, wrapping at COUNT; descending loop lets the nearest hit win.
  always_comb begin
    win = '0;
    idx = '0;
    for (int k = COUNT; k >= 1; k--) begin
      idx = GW'((int'(last_q) + k) % COUNT);
      if (S_REQ[idx]) win = idx;
    end
  end

  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    grant_d  = grant_q;
    p_req_d  = p_req_q;
    p_we_d   = p_we_q;
    p_addr_d = p_addr_q;
    p_din_d  = p_din_q;
    p_be_d   = p_be_q;
    s_ack_d  = '0;
    s_dout_d = s_dout_q;
`ifdef RAM_ARB_WATCHDOG_EN
    cnt_d    = cnt_q;
    err_d    = err_q;
`endif
    case (state_q)
      IDLE: begin
        if (|S_REQ) begin
          grant_d  = win;
          last_d   = win;
          p_req_d  = 1'b1;
          p_we_d   = S_WE[win];
          p_addr_d = addr_v[win];
          p_din_d  = din_v[win];
          p_be_d   = be_v[win];
          state_d  = WAIT;
`ifdef RAM_ARB_WATCHDOG_EN
          cnt_d    = TW'(TIMEOUT);
`endif
        end
      end
      WAIT: begin
        if (P_ACK) begin
          p_req_d  = 1'b0;
          s_dout_d = P_DOUT;
          s_ack_d  = COUNT'(1) << grant_q;
          state_d  = DONE;
        end
`ifdef RAM_ARB_WATCHDOG_EN
        // Expiry only when no ACK this cycle, so a simultaneous ACK still forwards data.
        else if (cnt_q == '0) begin
          p_req_d  = 1'b0;
          s_dout_d = '0;
          s_ack_d  = COUNT'(1) << grant_q;
          err_d    = 1'b1;
          state_d  = DONE;
        end else begin
          cnt_d    = cnt_q - TW'(1);
        end
`endif
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      state_q  <= IDLE;
      last_q   <= GW'(COUNT - 1);
      grant_q  <= '0;
      p_req_q  <= 1'b0;
      p_we_q   <= 1'b0;
      p_addr_q <= '0;
      p_din_q  <= '0;
      p_be_q   <= '0;
      s_ack_q  <= '0;
      s_dout_q <= '0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      grant_q  <= grant_d;
      p_req_q  <= p_req_d;
      p_we_q   <= p_we_d;
      p_addr_q <= p_addr_d;
      p_din_q  <= p_din_d;
      p_be_q   <= p_be_d;
      s_ack_q  <= s_ack_d;
      s_dout_q <= s_dout_d;
    end
  end

`ifdef RAM_ARB_WATCHDOG_EN
  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end
  assign ERR = err_q;
`else
  assign ERR = 1'b0;
`endif

  assign S_ACK  = s_ack_q;
  assign S_DOUT = s_dout_q;
  assign P_REQ  = p_req_q;
  assign P_WE   = p_we_q;
  assign P_ADDR = p_addr_q;
  assign P_DIN  = p_din_q;
  assign P_BE   = p_be_q;
  assign GRANT  = grant_q;
  assign BUSY   = (state_q == WAIT) || (state_q == DONE);

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: directed steps plus randomized transactions against a round-robin reference model.
// Watchdog cases are selected by RAM_ARB_WATCHDOG_EN.
module tb_ram_arbiter;
  localparam int COUNT = 4;
  localparam int AW    = 23;
  localparam int DW    = 32;
  localparam int BW    = DW / 8;
  localparam int GW    = $clog2(COUNT);
`ifdef RAM_ARB_WATCHDOG_EN
  localparam int TO    = 16;
`else
  localparam int TO    = 255;
`endif

  logic                 CLK = 1'b0;
  logic                 RESET_n;
  logic [COUNT-1:0]     S_REQ, S_WE, S_ACK;
  logic [COUNT*AW-1:0]  S_ADDR;
  logic [COUNT*DW-1:0]  S_DIN;
  logic [COUNT*BW-1:0]  S_BE;
  logic [DW-1:0]        S_DOUT, P_DIN, P_DOUT;
  logic                 P_REQ, P_WE, P_ACK, BUSY, ERR;
  logic [AW-1:0]        P_ADDR;
  logic [BW-1:0]        P_BE;
  logic [GW-1:0]        GRANT;

  ram_arbiter #(.COUNT(COUNT), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
    .CLK(CLK), .RESET_n(RESET_n),
    .S_REQ(S_REQ), .S_WE(S_WE), .S_ADDR(S_ADDR), .S_DIN(S_DIN), .S_BE(S_BE),
    .S_ACK(S_ACK), .S_DOUT(S_DOUT),
    .P_REQ(P_REQ), .P_WE(P_WE), .P_ADDR(P_ADDR), .P_DIN(P_DIN), .P_BE(P_BE),
    .P_ACK(P_ACK), .P_DOUT(P_DOUT),
    .GRANT(GRANT), .BUSY(BUSY), .ERR(ERR)
  );

  always #5 CLK = ~CLK;

  int vectors = 0;
  int miscompares = 0;
  int exp_last = COUNT - 1;

  logic [AW-1:0] sa[COUNT];
  logic [DW-1:0] sd[COUNT];
  logic [BW-1:0] sb[COUNT];
  logic          sw[COUNT];

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    vectors++;
    assert (obs === exp_v) else begin
      miscompares++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < COUNT; i++) begin
      S_ADDR[i*AW +: AW] = sa[i];
      S_DIN[i*DW +: DW]  = sd[i];
      S_BE[i*BW +: BW]   = sb[i];
      S_WE[i]            = sw[i];
    end
  endtask

  task automatic rand_fields();
    for (int i = 0; i < COUNT; i++) begin
      sa[i] = AW'($urandom);
      sd[i] = $urandom;
      sb[i] = BW'($urandom);
      sw[i] = 1'($urandom_range(0, 1));
    end
  endtask

  // First set bit strictly after 'last', wrapping modulo COUNT.
  function automatic int pick(input logic [COUNT-1:0] m, input int last);
    logic [COUNT-1:0] r;
    for (int k = 1; k <= COUNT; k++) begin
      r = m >> ((last + k) % COUNT);
      if (r[0]) return (last + k) % COUNT;
    end
    return -1;
  endfunction

  task automatic grant_step(input logic [COUNT-1:0] mask, output int w);
    S_REQ = mask;
    drive();
    tick();
    w = pick(mask, exp_last);
    exp_last = w;
    chk("grant_p_req", P_REQ, 1);
    chk("grant_idx", GRANT, w);
    chk("grant_addr", P_ADDR, sa[w]);
    chk("grant_we", P_WE, sw[w]);
    chk("grant_din", P_DIN, sd[w]);
    chk("grant_be", P_BE, sb[w]);
    chk("grant_busy", BUSY, 1);
    chk("grant_no_ack", S_ACK, 0);
  endtask

  task automatic txn(input logic [COUNT-1:0] mask, input int d, input logic [DW-1:0] rdata);
    int w;
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    logic [BW-1:0] eb;
    logic          ew;
    grant_step(mask, w);
    ea = sa[w]; ed = sd[w]; eb = sb[w]; ew = sw[w];
    for (int j = 0; j < d; j++) begin
      rand_fields();
      S_REQ  = COUNT'($urandom);
      P_DOUT = $urandom;
      drive();
      tick();
      chk("hold_p_req", P_REQ, 1);
      chk("hold_addr", P_ADDR, ea);
      chk("hold_din", P_DIN, ed);
      chk("hold_be", P_BE, eb);
      chk("hold_we", P_WE, ew);
      chk("hold_no_ack", S_ACK, 0);
    end
    P_ACK  = 1'b1;
    P_DOUT = rdata;
    tick();
    chk("ack_onehot", S_ACK, 64'(1) << w);
    chk("ack_dout", S_DOUT, rdata);
    chk("ack_p_req", P_REQ, 0);
    chk("ack_err", ERR, 0);
    P_ACK  = 1'b0;
    P_DOUT = $urandom;
    S_REQ  = '0;
    tick();
    chk("done_ack_clear", S_ACK, 0);
    chk("idle_busy", BUSY, 0);
  endtask

  initial begin
    int w;
    int n;
    logic seen;
    RESET_n = 1'b0;
    S_REQ = '0; P_ACK = 1'b0; P_DOUT = '0;
    rand_fields();
    drive();
    repeat (3) tick();
    RESET_n = 1'b1;
    chk("rst_p_req", P_REQ, 0);
    chk("rst_p_we", P_WE, 0);
    chk("rst_p_addr", P_ADDR, 0);
    chk("rst_p_din", P_DIN, 0);
    chk("rst_p_be", P_BE, 0);
    chk("rst_s_ack", S_ACK, 0);
    chk("rst_s_dout", S_DOUT, 0);
    chk("rst_grant", GRANT, 0);
    chk("rst_busy", BUSY, 0);
    chk("rst_err", ERR, 0);

    // First read from requester 0
    sa[0] = 23'h000123; sw[0] = 1'b0;
    txn(4'b0001, 0, 32'hDEADBEEF);

    // All four requesting: rotation continues from the last winner
    for (int i = 0; i < 5; i++) begin
      rand_fields();
      txn(4'b1111, i % 2, $urandom);
    end

    // Write from requester 2 held for several cycles
    rand_fields();
    sa[2] = 23'h7FFFFF; sd[2] = 32'h12345678; sb[2] = 4'b0101; sw[2] = 1'b1;
    txn(4'b0100, 3, $urandom);

    // Stray ACK while idle
    S_REQ = '0; P_ACK = 1'b1; P_DOUT = 32'hBAD0BAD0;
    tick();
    chk("stray_ack", S_ACK, 0);
    chk("stray_p_req", P_REQ, 0);
    P_ACK = 1'b0;
    tick();
    chk("stray_ack2", S_ACK, 0);

    // Reset while a transaction waits
    rand_fields();
    grant_step(4'b1000, w);
    RESET_n = 1'b0;
    #1;
    chk("midrst_p_req", P_REQ, 0);
    chk("midrst_grant", GRANT, 0);
    chk("midrst_busy", BUSY, 0);
    exp_last = COUNT - 1;
    S_REQ = '0;
    tick();
    RESET_n = 1'b1;
    P_ACK = 1'b1;
    tick();
    chk("midrst_no_ack", S_ACK, 0);
    P_ACK = 1'b0;
    tick();
    chk("midrst_no_ack2", S_ACK, 0);
    rand_fields();
    txn(4'b1010, 1, $urandom);

    // Randomized traffic
    for (int i = 0; i < 40; i++) begin
      rand_fields();
      txn(COUNT'($urandom_range(1, (1 << COUNT) - 1)), $urandom_range(0, 3), $urandom);
    end

`ifdef RAM_ARB_WATCHDOG_EN
    // ACK on the expiry cycle wins
    rand_fields();
    grant_step(4'b0001, w);
    S_REQ = '0;
    repeat (TO) tick();
    chk("tie_pre_ack", S_ACK, 0);
    P_ACK = 1'b1; P_DOUT = 32'hCAFEF00D;
    tick();
    chk("tie_ack", S_ACK, 64'(1) << w);
    chk("tie_dout", S_DOUT, 32'hCAFEF00D);
    chk("tie_err", ERR, 0);
    P_ACK = 1'b0;
    tick();

    // ACK withheld: watchdog fires TIMEOUT+1 cycles after P_REQ rises
    rand_fields();
    grant_step(4'b0010, w);
    S_REQ = '0;
    P_DOUT = 32'hFFFFFFFF;
    n = 0;
    while (n < 200) begin
      tick();
      n++;
      if (S_ACK != '0) break;
    end
    chk("wd_latency", n, TO + 1);
    chk("wd_ack", S_ACK, 64'(1) << w);
    chk("wd_dout", S_DOUT, 0);
    chk("wd_err", ERR, 1);
    chk("wd_p_req", P_REQ, 0);
    tick();
    chk("wd_err_sticky", ERR, 1);
    chk("wd_idle", BUSY, 0);
`else
    // Without the watchdog a missing ACK stalls forever
    rand_fields();
    grant_step(4'b0001, w);
    S_REQ = '0;
    seen = 1'b0;
    repeat (10000) begin
      tick();
      if (S_ACK != '0) seen = 1'b1;
    end
    chk("nowd_no_ack", seen, 0);
    chk("nowd_p_req", P_REQ, 1);
    chk("nowd_err", ERR, 0);
    P_ACK = 1'b1; P_DOUT = 32'h0F0F0F0F;
    tick();
    chk("nowd_late_ack", S_ACK, 64'(1) << w);
    chk("nowd_late_dout", S_DOUT, 32'h0F0F0F0F);
    P_ACK = 1'b0;
    tick();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Round-robin arbiter that shares one SDRAM controller request port between up to COUNT requesters, such as the MSX bus memory mapper, the boot/flash loader and the video fetch path. It sits between the requester-side RAM ports and the primary RAM port of the SDRAM controller, on the 108 MHz base clock domain. Exactly one transaction is outstanding at a time: the arbiter latches the winner's command, forwards it, and routes the completion back to the winner only.

## Interface
Parameters:
- COUNT, 4: number of requesters, 2..8.
- ADDR_WIDTH, 23: word address width.
- DATA_WIDTH, 32: data width.
- TIMEOUT, 255: watchdog limit in CLK cycles; only used when RAM_ARB_WATCHDOG_EN is defined.

Ports:
- CLK  in  1  base clock; single clock domain.
- RESET_n  in  1  asynchronous active-low reset.
- S_REQ  in  COUNT  per-requester level request.
- S_WE  in  COUNT  per-requester write enable (1 = write).
- S_ADDR  in  COUNT*ADDR_WIDTH  requester i's address is field [i*ADDR_WIDTH +: ADDR_WIDTH].
- S_DIN  in  COUNT*DATA_WIDTH  write data, packed the same way.
- S_BE  in  COUNT*DATA_WIDTH/8  byte enables, packed the same way.
- S_ACK  out  COUNT  one-cycle completion pulse; one-hot or zero.
- S_DOUT  out  DATA_WIDTH  read data; valid while S_ACK is nonzero.
- P_REQ, P_WE  out  1  request and write enable to the controller.
- P_ADDR  out  ADDR_WIDTH  address to the controller.
- P_DIN  out  DATA_WIDTH  write data to the controller.
- P_BE  out  DATA_WIDTH/8  byte enables to the controller.
- P_ACK  in  1  controller completion pulse.
- P_DOUT  in  DATA_WIDTH  controller read data, valid with P_ACK.
- GRANT  out  $clog2(COUNT)  index of the current or most recent winner.
- BUSY  out  1  high in the WAIT and DONE states.
- ERR  out  1  sticky watchdog flag.

## Operation
- The FSM has three states: IDLE, WAIT and DONE.
- IDLE:
  - If any S_REQ bit is high, pick the first set bit, searching from index last+1 and wrapping modulo COUNT.
  - Latch the winner's WE, ADDR, DIN and BE onto the P_* outputs, set P_REQ=1, set GRANT=winner and last=winner, then go to WAIT.
  - If no request is present, stay in IDLE.
- WAIT:
  - Hold P_* stable.
  - On P_ACK=1: clear P_REQ, register S_DOUT<=P_DOUT, set S_ACK to one-hot(GRANT), and go to DONE.
- DONE:
  - Hold for one cycle, then clear S_ACK and return to IDLE. No arbitration happens in DONE.
  - A requester must drop S_REQ on the edge after it sees its ACK.
  - An S_REQ bit still high when the FSM reaches IDLE is a new request.
- P_ACK is ignored in IDLE and DONE.
- S_REQ changes on non-granted lines never disturb a transaction in flight.
- A requester that drops S_REQ while granted does not cancel the transaction; it still completes and ACKs.
- On write transactions S_DOUT is loaded with whatever P_DOUT holds; requesters ignore it.
- Fairness: a requester that holds S_REQ waits at most COUNT-1 other transactions before it is granted.
- Reset mid-operation clears all state. The in-flight transaction's ACK is never delivered; the requester must reissue.
- When COUNT is not a power of two, the pointer arithmetic wraps at COUNT, not at 2^width.

## Timing
- Reset values: P_REQ, P_WE, P_ADDR, P_DIN, P_BE = 0; S_ACK = 0; S_DOUT = 0; GRANT = 0; BUSY = 0; ERR = 0; internal last = COUNT-1, so requester 0 has first priority after reset.
- S_REQ sampled at edge e0 in IDLE → P_REQ=1 after e0.
- P_ACK sampled at edge ek → S_ACK and S_DOUT valid after ek, for exactly one cycle → IDLE after ek+1.
- Minimum spacing between successive P_REQ assertions is 3 cycles when the controller ACKs in the cycle after the request.
- All outputs are registered; there is no combinational path from any input to any output.

## Configuration
- Macro: RAM_ARB_WATCHDOG_EN.
- Defined:
  - Load counter=TIMEOUT on entry to WAIT and decrement it each WAIT cycle.
  - If the counter reaches 0 without P_ACK: clear P_REQ, set S_DOUT=0, pulse S_ACK to the winner, set ERR=1 (sticky until reset), and go to DONE.
  - If P_ACK and expiry occur in the same cycle, P_ACK wins: data is forwarded and ERR is unchanged.
- Undefined: WAIT persists indefinitely, no counter logic is built, and ERR is tied to 0.

## Test plan
- **Reset value check:** after reset release, all outputs are 0; S_REQ=4'b0001 with ADDR=0x000123, WE=0 → P_REQ=1 and P_ADDR=0x000123 one cycle later; P_ACK with P_DOUT=0xDEADBEEF → S_ACK=4'b0001 and S_DOUT=0xDEADBEEF for exactly one cycle.
- **Round-robin order:** S_REQ=4'b1111 held, each requester dropping S_REQ after its ACK and re-raising it in IDLE → grant order 0,1,2,3,0; no requester is granted twice before all others.
- **Write forwarding:** requester 2 writes ADDR=0x7FFFFF, DIN=0x12345678, BE=4'b0101 → P_* show those exact values with P_WE=1 and hold them stable until P_ACK; only S_ACK[2] pulses.
- **Stray ACK and mid-transaction reset:** a P_ACK pulse in IDLE → no S_ACK; RESET_n asserted in WAIT → P_REQ=0 immediately, no S_ACK ever appears, and a subsequent request is served normally.
- **Watchdog expiry (RAM_ARB_WATCHDOG_EN, TIMEOUT=16):** P_ACK withheld → S_ACK pulses TIMEOUT+1 cycles after the P_REQ rise with S_DOUT=0, ERR=1, and P_REQ=0.
- **Watchdog tie:** P_ACK arriving on the expiry cycle → data is forwarded and ERR stays 0.
- **Watchdog disabled (RAM_ARB_WATCHDOG_EN undefined):** P_ACK withheld for 10000 cycles → P_REQ stays 1 and ERR stays 0.
